// File: rtl/par2ser.sv
// par2ser -- parallel-to-serial transmitter.
//
// Takes LENGTH-bit words through a valid/ready handshake. One word waits in a
// holding register while the shifter sends the previous one. Each bit leaves
// as a registered ovalid/odata pulse on a clock edge where enable is high.
// The bit order is picked per word. Back-to-back words stream with no idle
// bit slot between them.
//
// Ports:
//   clock   in   single clock, rising edge
//   reset   in   synchronous, active-low reset
//   enable  in   bit-rate strobe; a bit is emitted only on enabled edges
//   direct  in   bit order, sampled with the word (0 = LSB first, 1 = MSB first)
//   ivalid  in   parallel word valid
//   idata   in   parallel word [LENGTH]
//   iready  out  holding register empty (accept on ivalid & iready)
//   ovalid  out  registered; high for the cycle after each emitted bit
//   odata   out  registered serial bit
//   olast   out  registered; high with the final bit of a word
//   obusy   out  shifter or holding register holds data
module par2ser #(
    parameter int LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              direct,
    input  logic              ivalid,
    input  logic [LENGTH-1:0] idata,
    output logic              iready,
    output logic              ovalid,
    output logic              odata,
    output logic              olast,
    output logic              obusy
);

    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

    logic [LENGTH-1:0] hbuf;
    logic              hdir;
    logic              hfull;
    logic [LENGTH-1:0] sh;
    logic              sdir;
    logic              active;
    logic [CW-1:0]     cnt;

    logic emit;
    logic emit_last;
    logic accept;
    logic load;

    assign emit      = enable & active;
    assign emit_last = emit & (cnt == CNT_LAST);
    // The shifter is free when it is idle, or when it sends its last bit on this edge.
    assign load      = hfull & (~active | emit_last);
    assign accept    = ivalid & ~hfull;

    assign iready = ~hfull;
    assign obusy  = hfull | active;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hbuf   <= '0;
            hdir   <= 1'b0;
            hfull  <= 1'b0;
            sh     <= '0;
            sdir   <= 1'b0;
            active <= 1'b0;
            cnt    <= '0;
            ovalid <= 1'b0;
            odata  <= 1'b0;
            olast  <= 1'b0;
        end else begin
            // Accept needs hfull==0 and load needs hfull==1, so only one of
            // them can touch hbuf/hfull on any edge.
            if (accept) begin
                hbuf  <= idata;
                hdir  <= direct;
                hfull <= 1'b1;
            end

            if (emit) begin
                odata  <= sdir ? sh[LENGTH-1] : sh[0];
                ovalid <= 1'b1;
                olast  <= emit_last;
                sh     <= sdir ? {sh[LENGTH-2:0], 1'b0} : {1'b0, sh[LENGTH-1:1]};
                cnt    <= cnt + 1'b1;
                if (emit_last) begin
                    active <= 1'b0;
                end
            end else begin
                ovalid <= 1'b0;
                olast  <= 1'b0;
            end

            // A load comes last so it wins over the shift and the active clear
            // of the last bit. That lets the next word start on the next edge.
            if (load) begin
                sh     <= hbuf;
                sdir   <= hdir;
                cnt    <= '0;
                active <= 1'b1;
                hfull  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_par2ser.sv
module tb_par2ser;

    localparam int LENGTH = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              direct;
    logic              ivalid;
    logic [LENGTH-1:0] idata;
    logic              iready;
    logic              ovalid;
    logic              odata;
    logic              olast;
    logic              obusy;

    int checks = 0;
    int errors = 0;

    par2ser #(.LENGTH(LENGTH)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .direct (direct),
        .ivalid (ivalid),
        .idata  (idata),
        .iready (iready),
        .ovalid (ovalid),
        .odata  (odata),
        .olast  (olast),
        .obusy  (obusy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move past the next rising edge. Outputs are then stable, and new inputs
    // set here are sampled at the following edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one word at the next edge, then drop ivalid. After the call, the
    // accept edge (T) and the load edge (T+1) have passed, and no bit has gone out yet.
    task automatic send(input logic [7:0] w, input logic dir, input string tag);
        idata  = w;
        direct = dir;
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
        chk({tag, " iready after accept"}, iready, 0);
        chk({tag, " obusy after accept"}, obusy, 1);
        chk({tag, " ovalid T"}, ovalid, 0);
        tick();
        chk({tag, " ovalid T+1"}, ovalid, 0);
        chk({tag, " iready after load"}, iready, 1);
    endtask

    // seq[i] is the i-th bit expected on the wire. Checks 8 contiguous bits.
    task automatic recv(input logic [7:0] seq, input string tag);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("%s ovalid bit%0d", tag, i), ovalid, 1);
            chk($sformatf("%s odata bit%0d", tag, i), odata, seq[i]);
            chk($sformatf("%s olast bit%0d", tag, i), olast, (i == 7) ? 1 : 0);
        end
    endtask

    initial begin
        int pulses;
        reset  = 1'b0;
        enable = 1'b1;
        direct = 1'b0;
        ivalid = 1'b1;           // must be ignored while reset is asserted
        idata  = 8'hFF;

        // Reset / idle
        tick();
        chk("rst ovalid", ovalid, 0);
        chk("rst odata", odata, 0);
        chk("rst olast", olast, 0);
        chk("rst iready", iready, 1);
        chk("rst obusy", obusy, 0);
        tick();
        chk("rst2 obusy", obusy, 0);
        ivalid = 1'b0;
        reset  = 1'b1;
        tick();
        chk("idle iready", iready, 1);
        chk("idle ovalid", ovalid, 0);
        chk("idle olast", olast, 0);
        chk("idle obusy", obusy, 0);

        // LSB first, 0x1E -> 0,1,1,1,1,0,0,0
        send(8'h1E, 1'b0, "lsb");
        recv(8'b0001_1110, "lsb");
        tick();
        chk("lsb ovalid after", ovalid, 0);
        chk("lsb obusy after", obusy, 0);

        // MSB first, 0x1E -> 0,0,0,1,1,1,1,0
        send(8'h1E, 1'b1, "msb");
        direct = 1'b0;           // a change mid-word must have no effect
        recv(8'b0111_1000, "msb");
        chk("msb obusy after last emit", obusy, 0);
        tick();
        chk("msb ovalid after", ovalid, 0);

        // Streaming with ivalid held high: 0xA5 then 0x3C, LSB first
        idata  = 8'hA5;
        direct = 1'b0;
        ivalid = 1'b1;
        tick();                  // T: accept A5
        idata = 8'h3C;
        chk("str iready T", iready, 0);
        tick();                  // T+1: load A5
        chk("str iready T+1", iready, 1);
        chk("str ovalid T+1", ovalid, 0);
        tick();                  // T+2: accept 3C, emit A5 bit0
        ivalid = 1'b0;
        chk("str ovalid b0", ovalid, 1);
        chk("str odata b0", odata, 1);
        chk("str iready full", iready, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("str A5 ovalid b%0d", i), ovalid, 1);
            chk($sformatf("str A5 odata b%0d", i), odata, (8'hA5 >> i) & 1);
            chk($sformatf("str A5 olast b%0d", i), olast, (i == 7) ? 1 : 0);
            chk($sformatf("str iready b%0d", i), iready, (i == 7) ? 1 : 0);
        end
        recv(8'h3C, "str 3C");
        tick();
        chk("str ovalid end", ovalid, 0);
        chk("str obusy end", obusy, 0);

        // Enable gating, 0xFF, enable pattern 1,0,0,...
        enable = 1'b0;
        send(8'hFF, 1'b0, "en");
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            enable = (k % 3 == 0);
            tick();
            chk($sformatf("en ovalid k%0d", k), ovalid, (k % 3 == 0) ? 1 : 0);
            if (ovalid) begin
                pulses++;
                chk($sformatf("en odata k%0d", k), odata, 1);
            end
            chk($sformatf("en olast k%0d", k), olast, (k == 21) ? 1 : 0);
        end
        chk("en pulse count", pulses, 8);
        chk("en obusy end", obusy, 0);
        enable = 1'b1;

        // Reset mid-word
        send(8'h1E, 1'b0, "mid");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid odata b%0d", i), odata, (8'h1E >> i) & 1);
        end
        reset = 1'b0;
        tick();
        chk("mid rst ovalid", ovalid, 0);
        chk("mid rst obusy", obusy, 0);
        chk("mid rst odata", odata, 0);
        chk("mid rst iready", iready, 1);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ovalid) pulses++;
        end
        chk("mid no trailing bits", pulses, 0);
        send(8'h01, 1'b0, "new");
        recv(8'b0000_0001, "new");
        tick();
        chk("new ovalid end", ovalid, 0);
        chk("new obusy end", obusy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par2ser.md
Name: par2ser

Overview:
- Parallel-to-serial transmitter; the counterpart of the serial-to-parallel receiver in the same library.
- Accepts LENGTH-bit words through a valid/ready handshake and buffers one word in a holding register.
- Emits one bit per enabled clock as a registered ovalid/odata pulse, the format the receiver's ivalid/idata consumes.
- Bit order is selectable per word; back-to-back words stream with no idle bit slot.

Parameters:
- LENGTH, 8, word width in bits; legal range LENGTH >= 2.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clock edge).
- enable  input  1  bit-rate strobe; a bit is emitted only on edges where enable==1.
- direct  input  1  bit order, sampled with the word: 0 = LSB first, 1 = MSB first.
- ivalid  input  1  parallel word valid.
- idata  input  LENGTH  parallel word.
- iready  output  1  holding register empty; word accepted on an edge where ivalid & iready.
- ovalid  output  1  registered; high for exactly the cycle after each emitted bit edge.
- odata  output  1  registered serial bit, meaningful when ovalid==1.
- olast  output  1  registered; high with the final bit of a word.
- obusy  output  1  high while the shifter or the holding register holds data.

Behaviour:
- Internal state: holding register hbuf[LENGTH], hdir, hfull; shifter sh[LENGTH], sdir, active; counter cnt[$clog2(LENGTH)].
- Reset (reset==0 at an edge) clears hfull, active, cnt, sh, hbuf, ovalid, odata and olast. Reset overrides every other input.
- A partially sent word is dropped on reset; no trailing bits are emitted.
- iready = ~hfull (combinational from a register). obusy = hfull | active.
- Accept: on an edge with ivalid & iready, hbuf <= idata, hdir <= direct, hfull <= 1. Not gated by enable.
- Load: on an edge where hfull==1 and the shifter is free, sh <= hbuf, sdir <= hdir, cnt <= 0, active <= 1, hfull <= 0.
  - The shifter is free when active==0, or when active==1 and this edge emits the last bit.
  - Load is not gated by enable.
- Emit: on an edge with enable==1 and active==1:
  - odata <= sdir ? sh[LENGTH-1] : sh[0]; ovalid <= 1; olast <= (cnt==LENGTH-1).
  - sh shifts toward the emitted end, zero fill; cnt <= cnt+1.
  - When cnt==LENGTH-1: active <= 0, unless a load occurs on the same edge.
- On any edge that does not emit, ovalid <= 0 and olast <= 0; odata holds its value.
- enable==0 freezes sh and cnt; there is no timeout.
- Latency, idle block, enable held high:
  - word accepted at edge T, loaded at T+1, first bit emitted at T+2;
  - ovalid is high in the cycles after edges T+2 .. T+LENGTH+1.
- Streaming: if hbuf is full when the last bit is emitted, the new word loads on that edge and its first bit emits on the next edge. No gap.
- Accept and load on the same edge cannot both target hbuf, because accept requires hfull==0. hfull clears at load, so iready rises the cycle after a load.
- direct and idata are ignored except at the accept edge. Changing direct mid-word has no effect.
- With direct==0, loopback into the library receiver (same LENGTH, its direct==0) reproduces idata exactly.

Test Plan:
- Reset/idle: hold reset=0 for 2 edges, then release -> iready=1, ovalid=0, olast=0, obusy=0; all outputs 0 during reset.
- LSB-first: LENGTH=8, enable=1, accept 0x1E with direct=0 -> odata sequence 0,1,1,1,1,0,0,0; ovalid high 8 consecutive cycles; olast only on the 8th bit; first ovalid 2 edges after accept.
- MSB-first: accept 0x1E with direct=1 -> odata 0,0,0,1,1,1,1,0; olast on the 8th bit; obusy drops one cycle after the last emit.
- Streaming/backpressure: offer 0xA5 then 0x3C with ivalid held high -> second word waits with iready=0 and is accepted one cycle after the first load. 16 contiguous ovalid pulses; olast on bits 8 and 16; iready low while hbuf is full.
- Enable gating: enable pattern 1,0,0,1,... on 0xFF -> exactly 8 ovalid pulses, each only after an enabled edge; no bit lost or duplicated; cnt frozen while enable=0.
- Reset mid-word: assert reset after 3 bits of 0x1E -> no further ovalid, obusy=0. A new word 0x01 (direct=0) then emits 1,0,0,0,0,0,0,0 from the start.
